// File: rtl/mont_expo_job_scheduler.sv
// Job sequencer and two-way round-robin arbiter for the shared Montgomery exponentiation engine:
// loads the granted operand, drives constant-memory indices, forwards tagged results, resets the engine between jobs.
module mont_expo_job_scheduler #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 4096,
  parameter int EXP_BITS      = BITS_IN_NUM / 2
) (
  input  logic                                           clk_in,
  input  logic                                           rst_n_in,
  input  logic [1:0]                                     req_valid_in,
  input  logic [REGISTER_SIZE-1:0]                       req0_block_in,
  input  logic [REGISTER_SIZE-1:0]                       req1_block_in,
  output logic [1:0]                                     req_ready_out,
  output logic [REGISTER_SIZE-1:0]                       eng_block_out,
  output logic                                           eng_valid_out,
  output logic                                           eng_rst_out,
  input  logic                                           eng_consumed_k_in,
  input  logic                                           eng_consumed_nsq_in,
  input  logic                                           eng_consumed_n_in,
  input  logic                                           eng_valid_in,
  input  logic [REGISTER_SIZE-1:0]                       eng_data_in,
  output logic [$clog2(BITS_IN_NUM/REGISTER_SIZE)-1:0]   k_addr_out,
  output logic [$clog2(BITS_IN_NUM/REGISTER_SIZE)-1:0]   nsq_addr_out,
  output logic [$clog2(EXP_BITS)-1:0]                    n_bit_idx_out,
  output logic                                           res_valid_out,
  output logic [REGISTER_SIZE-1:0]                       res_data_out,
  output logic                                           res_id_out,
  output logic                                           busy_out,
  output logic [15:0]                                    jobs_done_out
);

  localparam int NB = BITS_IN_NUM / REGISTER_SIZE;
  localparam int AW = $clog2(NB);
  localparam int NW = $clog2(EXP_BITS);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, FLUSH} state_t;

  state_t        state, state_nx;
  logic          grant, grant_nx;
  logic          last_grant;
  logic [CW-1:0] load_cnt, res_cnt;
  logic          accept, res_take, idx_en;

  assign eng_rst_out = (state == FLUSH) | ~rst_n_in;
  assign busy_out    = (state != IDLE);
  assign idx_en      = (state == LOAD) || (state == COMPUTE);

  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    req_ready_out = '0;
    eng_block_out = '0;
    eng_valid_out = 1'b0;
    accept        = 1'b0;
    res_take      = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid_in) begin
          state_nx = LOAD;
          // On a tie the requester not served last wins; otherwise the lone requester.
          grant_nx = (&req_valid_in) ? ~last_grant : req_valid_in[1];
        end
      end
      LOAD: begin
        req_ready_out[grant] = (load_cnt < CW'(NB));
        eng_block_out        = grant ? req1_block_in : req0_block_in;
        accept               = req_valid_in[grant] & req_ready_out[grant];
        eng_valid_out        = accept;
        if (accept && load_cnt == CW'(NB - 1)) state_nx = COMPUTE;
      end
      COMPUTE: begin
        res_take = eng_valid_in;
        if (eng_valid_in && res_cnt == CW'(NB - 1)) state_nx = FLUSH;
      end
      FLUSH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      load_cnt      <= '0;
      res_cnt       <= '0;
      k_addr_out    <= '0;
      nsq_addr_out  <= '0;
      n_bit_idx_out <= '0;
      res_valid_out <= 1'b0;
      res_data_out  <= '0;
      res_id_out    <= 1'b0;
      jobs_done_out <= '0;
    end else begin
      state         <= state_nx;
      grant         <= grant_nx;
      res_valid_out <= res_take;
      if (accept) load_cnt <= load_cnt + CW'(1);
      if (res_take) begin
        res_cnt      <= res_cnt + CW'(1);
        res_data_out <= eng_data_in;
        res_id_out   <= grant;
      end
      if (idx_en) begin
        if (eng_consumed_k_in)
          k_addr_out <= (k_addr_out == AW'(NB - 1)) ? '0 : k_addr_out + AW'(1);
        if (eng_consumed_nsq_in)
          nsq_addr_out <= (nsq_addr_out == AW'(NB - 1)) ? '0 : nsq_addr_out + AW'(1);
        if (eng_consumed_n_in)
          n_bit_idx_out <= (n_bit_idx_out == NW'(EXP_BITS - 1)) ? '0 : n_bit_idx_out + NW'(1);
      end
      // FLUSH never overlaps accept/result/index activity, so these clears cannot collide.
      if (state == FLUSH) begin
        load_cnt      <= '0;
        res_cnt       <= '0;
        k_addr_out    <= '0;
        nsq_addr_out  <= '0;
        n_bit_idx_out <= '0;
        jobs_done_out <= jobs_done_out + 16'd1;
        last_grant    <= grant;
      end
    end
  end

endmodule
